// File: rtl/param_rr_arb_2x1.sv
// Two-source round-robin arbiter feeding a one-entry output register.
// The register refills on the same cycle it drains, so a busy consumer sees no bubbles.
module param_rr_arb_2x1 #(
  parameter int N = 3,
  localparam int W = 2**N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x0_data,
  input  logic         x0_valid,
  output logic         x0_ready,
  input  logic [W-1:0] x1_data,
  input  logic         x1_valid,
  output logic         x1_ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         sel
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;
  logic   last_grant;
  logic   can_load;
  logic   any_valid;
  logic   grant;
  logic   load;

  assign y_valid   = (state == FULL);
  assign can_load  = !y_valid | y_ready;
  assign any_valid = x0_valid | x1_valid;

  // A tie goes to whichever source did not win the previous load.
  assign grant    = (x0_valid & x1_valid) ? !last_grant : x1_valid;
  assign load     = can_load & any_valid & !reset;
  assign x0_ready = load & !grant;
  assign x1_ready = load & grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      y_data     <= '0;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      state      <= FULL;
      y_data     <= grant ? x1_data : x0_data;
      sel        <= grant;
      last_grant <= grant;
    end else if (y_valid && y_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_param_rr_arb_2x1.sv
// Self-checking bench for param_rr_arb_2x1: expected words are queued when a
// source is driven and popped when the output register shows the new word.
module tb_param_rr_arb_2x1;

  localparam int N = 3;
  localparam int W = 2**N;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] x0_data, x1_data, y_data;
  logic         x0_valid, x1_valid, x0_ready, x1_ready;
  logic         y_valid, y_ready, sel;

  int compared   = 0;
  int mismatched = 0;
  logic         model_last;
  logic [W:0]   sb[$];
  logic [W:0]   exp_word;

  param_rr_arb_2x1 #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .x0_data(x0_data), .x0_valid(x0_valid), .x0_ready(x0_ready),
    .x1_data(x1_data), .x1_valid(x1_valid), .x1_ready(x1_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1, input logic yr);
    x0_valid = v0; x0_data = d0;
    x1_valid = v1; x1_data = d1;
    y_ready  = yr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1);
    tick();
    tick();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b0, 1'b0, 8'h00}) begin
      mismatched++;
      $display("[TB] FAIL reset_out: got v=%b sel=%b d=%h, want v=0 sel=0 d=00", y_valid, sel, y_data);
    end
    compared++;
    if ({x0_ready, x1_ready} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b%b, want 00", x0_ready, x1_ready);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_single_source();
    drive(1'b1, 8'hA5, 1'b0, 8'h5A, 1'b1);
    #1;
    compared++;
    if ({x0_ready, x1_ready} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL single_ready: got %b%b, want 10", x0_ready, x1_ready);
    end
    sb.push_back({1'b0, 8'hA5});
    model_last = 1'b0;
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_word = sb.pop_front();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b1, exp_word}) begin
      mismatched++;
      $display("[TB] FAIL single_out: got v=%b sel=%b d=%h, want v=1 %h", y_valid, sel, y_data, exp_word);
    end
    tick();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b0, 1'b0, 8'hA5}) begin
      mismatched++;
      $display("[TB] FAIL single_drain: got v=%b sel=%b d=%h, want v=0 sel=0 d=a5", y_valid, sel, y_data);
    end
  endtask

  task automatic test_round_robin();
    logic g;
    // Start from reset so the first tie goes to x0.
    test_reset();
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 4; i++) begin
      g = !model_last;
      #1;
      compared++;
      if ({x0_ready, x1_ready} !== {!g, g}) begin
        mismatched++;
        $display("[TB] FAIL rr_ready[%0d]: got %b%b, want %b%b", i, x0_ready, x1_ready, !g, g);
      end
      sb.push_back({g, g ? 8'h22 : 8'h11});
      model_last = g;
      tick();
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL rr_sb[%0d]: got empty queue, want entry", i);
      end else begin
        exp_word = sb.pop_front();
        compared++;
        if ({y_valid, sel, y_data} !== {1'b1, exp_word}) begin
          mismatched++;
          $display("[TB] FAIL rr_out[%0d]: got v=%b sel=%b d=%h, want v=1 %h", i, y_valid, sel, y_data, exp_word);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    sb.push_back({1'b0, 8'h11});
    model_last = 1'b0;
    tick();
    exp_word = sb.pop_front();
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if ({x0_ready, x1_ready} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL bp_ready[%0d]: got %b%b, want 00", i, x0_ready, x1_ready);
      end
      tick();
      compared++;
      if ({y_valid, sel, y_data} !== {1'b1, exp_word}) begin
        mismatched++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b sel=%b d=%h, want v=1 %h", i, y_valid, sel, y_data, exp_word);
      end
    end
    y_ready = 1'b1;
    #1;
    compared++;
    if ({x0_ready, x1_ready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL bp_release_ready: got %b%b, want 01", x0_ready, x1_ready);
    end
    sb.push_back({1'b1, 8'h22});
    model_last = 1'b1;
    tick();
    exp_word = sb.pop_front();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b1, exp_word}) begin
      mismatched++;
      $display("[TB] FAIL bp_release_out: got v=%b sel=%b d=%h, want v=1 %h", y_valid, sel, y_data, exp_word);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
  endtask

  task automatic test_priority_memory();
    drive(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
    #1;
    compared++;
    if ({x0_ready, x1_ready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL prio_lone_ready: got %b%b, want 01", x0_ready, x1_ready);
    end
    sb.push_back({1'b1, 8'h33});
    model_last = 1'b1;
    tick();
    exp_word = sb.pop_front();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b1, exp_word}) begin
      mismatched++;
      $display("[TB] FAIL prio_lone_out: got v=%b sel=%b d=%h, want v=1 %h", y_valid, sel, y_data, exp_word);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    compared++;
    if (y_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL prio_idle: got v=%b, want v=0", y_valid);
    end
    drive(1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
    #1;
    compared++;
    if ({x0_ready, x1_ready} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL prio_tie_ready: got %b%b, want 10", x0_ready, x1_ready);
    end
    sb.push_back({1'b0, 8'h55});
    model_last = 1'b0;
    tick();
    exp_word = sb.pop_front();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b1, exp_word}) begin
      mismatched++;
      $display("[TB] FAIL prio_tie_out: got v=%b sel=%b d=%h, want v=1 %h", y_valid, sel, y_data, exp_word);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
    tick();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b1, 1'b0, 8'h44}) begin
      mismatched++;
      $display("[TB] FAIL mid_full: got v=%b sel=%b d=%h, want v=1 sel=0 d=44", y_valid, sel, y_data);
    end
    drive(1'b1, 8'h99, 1'b1, 8'h98, 1'b1);
    reset = 1'b1;
    #1;
    compared++;
    if ({x0_ready, x1_ready} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_ready: got %b%b, want 00", x0_ready, x1_ready);
    end
    tick();
    compared++;
    if ({y_valid, y_data} !== {1'b0, 8'h00}) begin
      mismatched++;
      $display("[TB] FAIL mid_drop: got v=%b d=%h, want v=0 d=00", y_valid, y_data);
    end
    reset = 1'b0;
    model_last = 1'b1;
    drive(1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
    #1;
    sb.push_back({!model_last, 8'h77});
    tick();
    exp_word = sb.pop_front();
    compared++;
    if ({y_valid, sel, y_data} !== {1'b1, exp_word}) begin
      mismatched++;
      $display("[TB] FAIL mid_tie_out: got v=%b sel=%b d=%h, want v=1 %h", y_valid, sel, y_data, exp_word);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    model_last = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_priority_memory();
    test_reset_mid();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sb_leftover: got %0d entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/param_rr_arb_2x1.md
Name: param_rr_arb_2x1

Overview:
- Two-source round-robin arbiter with a one-entry output register. Sits directly upstream of the parameterised 2:1 mux stage.
- Accepts two valid/ready data streams of width 2**N and grants one per cycle.
- Drives the granted word on y_data and the select that chose it on sel.
- Downstream mux/consumer pulls words with a valid/ready handshake.

Parameters:
N, 3, log2 of data width; data width W = 2**N (8 bits at default)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
x0_data  input  W  source 0 data
x0_valid  input  1  source 0 has a word
x0_ready  output  1  source 0 word accepted this cycle
x1_data  input  W  source 1 data
x1_valid  input  1  source 1 has a word
x1_ready  output  1  source 1 word accepted this cycle
y_data  output  W  registered granted word
y_valid  output  1  y_data holds a word
y_ready  input  1  downstream accepts y_data
sel  output  1  source index of the word in y_data (0 = x0, 1 = x1)

Behaviour:
- Reset (reset=1 at a rising edge):
  - y_valid=0, y_data=0, sel=0.
  - Internal last_grant=1, so x0 wins the first tie.
  - Held word is discarded, including a reset mid-transfer.
  - x0_ready/x1_ready read 0 while reset is high.
- State: EMPTY (y_valid=0) or FULL (y_valid=1).
- can_load = !y_valid | y_ready.
- Grant (combinational, same cycle):
  - only x0_valid -> grant 0; only x1_valid -> grant 1.
  - both valid -> grant = !last_grant; neither -> no grant.
- xK_ready = can_load & xK_valid & (grant==K) & !reset. At most one ready is high per cycle. Ready depends on valid by design.
- Load (rising edge, can_load and a grant):
  - y_data <= granted data, sel <= grant, y_valid <= 1, last_grant <= grant.
- Pop without load (can_load, no grant, y_valid & y_ready): y_valid <= 0; y_data, sel and last_grant hold.
- Transitions:
  - EMPTY -> FULL on a load.
  - FULL -> FULL on simultaneous pop and load (word replaced, no bubble).
  - FULL -> EMPTY on pop with no grant.
  - FULL held while y_ready=0.
- Latency 1 cycle from input handshake to y_valid. Throughput 1 word/cycle while y_ready=1.
- Backpressure (FULL, y_ready=0): both readies 0; y_data, sel and y_valid stable.
- last_grant updates only on an actual load. It does not change on idle cycles or stalls.
- Tie-break runs only when both are valid. A lone requester is never blocked by priority.
- No data width conversion; data passes bit-exact.

Test Plan:
- Reset check: assert reset 2 cycles with x0_valid=x1_valid=1 -> y_valid=0, y_data=8'h00, sel=0, x0_ready=x1_ready=0.
- Single source: x0_valid=1, x0_data=8'hA5, y_ready=1 -> x0_ready=1 the same cycle; next cycle y_valid=1, y_data=8'hA5, sel=0; x1_ready stays 0.
- Round robin: both valid continuously, x0_data=8'h11, x1_data=8'h22, y_ready=1 -> y_data sequence 11,22,11,22 with sel 0,1,0,1, one word per cycle.
- Backpressure: FULL with 8'h11, y_ready=0 for 3 cycles, both valid -> readies 0, y_data=8'h11 stable. On y_ready=1, 8'h22 (x1) loads the next cycle with no bubble.
- Priority memory: x1 alone sends 8'h33, then 2 idle cycles, then both valid -> x0 granted first (last_grant=1 retained).
- Reset mid-operation: FULL with 8'h44, y_ready=0, assert reset -> y_valid=0 next cycle, word dropped. After release, a tie grants x0 first.
